// File: rtl/ramio_pkg.sv
// ramio_pkg: shared types and lane helpers for the ramio load/store front end.
//   size_e       access size encoding (byte/half/word, 3 = illegal)
//   state_e      front-end FSM states
//   lane_mask    byte-lane write mask for a size/offset pair
//   lane_data    store data moved onto its byte lanes
//   load_extend  lane extraction plus sign/zero extension of a read word
package ramio_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WAIT,
        ST_RESPOND
    } state_e;

    function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input size_e size, input logic [1:0] off,
                                              input logic [31:0] wdata);
        logic [4:0] sh;
        sh = {off, 3'b000};
        case (size)
            SZ_BYTE: return {24'h0, wdata[7:0]} << sh;
            SZ_HALF: return {16'h0, wdata[15:0]} << sh;
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input size_e size, input logic is_unsigned,
                                                input logic [1:0] off, input logic [31:0] word);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: return is_unsigned ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: return is_unsigned ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: return shifted;
        endcase
    endfunction

endpackage

// File: rtl/ramio_if.sv
// ramio_if: CPU-side request/response bus of the ramio front end.
//   req_valid/req_ready  request handshake (accepted when both high)
//   req_write/req_size/req_unsigned/req_address/req_wdata  request fields
//   rsp_valid/rsp_rdata/rsp_error  one-cycle response
// master = CPU side, slave = ramio.
interface ramio_if;
    import ramio_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    size_e       req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/ramio.sv
// ramio: load/store front end in front of the SDRAM line cache.
//   clk, rst_n             clock, asynchronous active-low reset
//   bus                    ramio_if.slave request/response bus
//   cache_enable           cache access strobe (Settle and Wait states)
//   cache_address          word-aligned cache address
//   cache_data_in          lane-aligned store data
//   cache_write_enable     byte-lane write mask, 0 for loads
//   cache_data_out         cache read word
//   cache_data_out_ready   cache read hit
//   cache_busy             cache miss / line fill in progress
//   led                    memory-mapped LED register
module ramio
    import ramio_pkg::*;
#(
    parameter logic [31:0] MemTopAddress = 32'h0000_1000,
    parameter logic [31:0] LedAddress    = 32'hFFFF_FFFC,
    parameter int unsigned LedWidth      = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    ramio_if.slave              bus,
    output logic                cache_enable,
    output logic [31:0]         cache_address,
    output logic [31:0]         cache_data_in,
    output logic [3:0]          cache_write_enable,
    input  logic [31:0]         cache_data_out,
    input  logic                cache_data_out_ready,
    input  logic                cache_busy,
    output logic [LedWidth-1:0] led
);

    state_e              r_state;
    state_e              w_next;
    logic                r_live;
    logic                r_write;
    size_e               r_size;
    logic                r_unsigned;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_error;
    logic [31:0]         r_rdata;
    logic [LedWidth-1:0] r_led;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_is_led;
    logic        w_error;
    logic [31:0] w_led_ext;

    // Decode of the live request; only meaningful while accepting in Idle.
    always_comb begin
        w_misaligned = (bus.req_size == SZ_HALF && bus.req_address[0])
                    || (bus.req_size == SZ_WORD && bus.req_address[1:0] != 2'b00)
                    || (bus.req_size == SZ_BAD);
        w_is_led     = (bus.req_address[31:2] == LedAddress[31:2]);
        w_error      = w_misaligned || (bus.req_address >= MemTopAddress && !w_is_led);
        w_led_ext    = '0;
        w_led_ext[LedWidth-1:0] = r_led;
    end

    // r_live holds off req_ready for the first edge after reset release.
    assign bus.req_ready = r_live && (r_state == ST_IDLE);
    assign w_accept      = bus.req_valid && bus.req_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = (w_error || w_is_led) ? ST_RESPOND : ST_SETTLE;
            end
            // Tag BRAM output is not valid yet, so cache_busy is ignored here.
            ST_SETTLE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (!cache_busy && (r_write || cache_data_out_ready)) w_next = ST_RESPOND;
            end
            ST_RESPOND: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_live     <= 1'b0;
            r_write    <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_error    <= 1'b0;
            r_rdata    <= '0;
            r_led      <= '0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_write    <= bus.req_write;
                r_size     <= bus.req_size;
                r_unsigned <= bus.req_unsigned;
                r_addr     <= bus.req_address;
                r_wdata    <= bus.req_wdata;
                r_error    <= w_error;
                r_rdata    <= '0;
                if (!w_error && w_is_led) begin
                    if (bus.req_write) r_led   <= bus.req_wdata[LedWidth-1:0];
                    else               r_rdata <= w_led_ext;
                end
            end
            if (r_state == ST_WAIT && !r_write && !cache_busy && cache_data_out_ready)
                r_rdata <= load_extend(r_size, r_unsigned, r_addr[1:0], cache_data_out);
        end
    end

    // Cache-side outputs come straight from the latched request so they stay
    // stable for the whole Settle/Wait window regardless of the CPU inputs.
    always_comb begin
        cache_enable       = (r_state == ST_SETTLE) || (r_state == ST_WAIT);
        cache_address      = '0;
        cache_data_in      = '0;
        cache_write_enable = '0;
        if (cache_enable) begin
            cache_address = {r_addr[31:2], 2'b00};
            cache_data_in = lane_data(r_size, r_addr[1:0], r_wdata);
            if (r_write) cache_write_enable = lane_mask(r_size, r_addr[1:0]);
        end
    end

    assign bus.rsp_valid = (r_state == ST_RESPOND);
    assign bus.rsp_rdata = (r_state == ST_RESPOND) ? r_rdata : '0;
    assign bus.rsp_error = (r_state == ST_RESPOND) && r_error;
    assign led           = r_led;

endmodule

// File: tb/tb_ramio.sv
// tb_ramio: directed bench for ramio with a small direct-mapped cache model
// (16-byte lines, 2 KB, flat backing memory, 3-cycle fill, +3 cycles when
// the victim line is dirty).
module tb_ramio;
    import ramio_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cache_enable;
    logic [31:0] cache_address;
    logic [31:0] cache_data_in;
    logic [3:0]  cache_write_enable;
    logic [31:0] cache_data_out;
    logic        cache_data_out_ready;
    logic        cache_busy;
    logic [5:0]  led;

    int n_cmp = 0;
    int n_bad = 0;

    ramio_if bus ();

    ramio #(
        .MemTopAddress(32'h0000_1000),
        .LedAddress   (32'hFFFF_FFFC),
        .LedWidth     (6)
    ) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .bus                 (bus),
        .cache_enable        (cache_enable),
        .cache_address       (cache_address),
        .cache_data_in       (cache_data_in),
        .cache_write_enable  (cache_write_enable),
        .cache_data_out      (cache_data_out),
        .cache_data_out_ready(cache_data_out_ready),
        .cache_busy          (cache_busy),
        .led                 (led)
    );

    always #5 clk = ~clk;

    // ---------------- cache + SDRAM model ----------------
    logic [31:0] mem   [0:1023];
    logic        tag_v [0:127];
    logic [20:0] tag   [0:127];
    logic        dirty [0:127];
    logic        en_d;
    int          busy_cnt;
    logic [6:0]  m_idx;

    assign m_idx                = cache_address[10:4];
    assign cache_busy           = (busy_cnt != 0);
    assign cache_data_out       = mem[cache_address[11:2]];
    assign cache_data_out_ready = cache_enable && !cache_busy;

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] t;
        if (!rst_n) begin
            en_d     <= 1'b0;
            busy_cnt <= 0;
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[10'h204] <= 32'h5A5A_1234;   // word at 0x810
            for (int i = 0; i < 128; i++) begin
                tag_v[i] <= 1'b0;
                tag[i]   <= 21'h0;
                dirty[i] <= 1'b0;
            end
        end else begin
            en_d <= cache_enable;
            if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) begin
                    tag_v[m_idx] <= 1'b1;
                    tag[m_idx]   <= cache_address[31:11];
                    dirty[m_idx] <= 1'b0;
                end
            end else if (cache_enable && !en_d) begin
                if (!tag_v[m_idx] || tag[m_idx] != cache_address[31:11])
                    busy_cnt <= dirty[m_idx] ? 6 : 3;
            end else if (cache_enable && cache_write_enable != 4'b0000) begin
                t = mem[cache_address[11:2]];
                for (int b = 0; b < 4; b++)
                    if (cache_write_enable[b]) t[8*b +: 8] = cache_data_in[8*b +: 8];
                mem[cache_address[11:2]] <= t;
                dirty[m_idx] <= 1'b1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One full transaction. lat = negedges from accept edge to rsp_valid.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er,
                          output logic [3:0] mk, output logic en,
                          output int lat, output logic [31:0] cadr,
                          output logic stable);
        int   n;
        logic got;
        rd = '0; er = 1'b0; mk = '0; en = 1'b0; lat = 0; cadr = '0; stable = 1'b1;
        got = 1'b0;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = size_e'(sz);
        bus.req_unsigned = uns;
        bus.req_address  = addr;
        bus.req_wdata    = wdata;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'(bus.req_ready), 32'h1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble the request fields: the DUT must work from its latched copy.
        bus.req_valid    = 1'b0;
        bus.req_write    = ~wr;
        bus.req_size     = SZ_BAD;
        bus.req_unsigned = ~uns;
        bus.req_address  = 32'hDEAD_BEEF;
        bus.req_wdata    = 32'hFFFF_FFFF;
        while (lat < 40 && !got) begin
            @(negedge clk);
            lat++;
            if (cache_enable) begin
                if (!en) cadr = cache_address;
                else if (cache_address !== cadr) stable = 1'b0;
                en = 1'b1;
            end
            mk = mk | cache_write_enable;
            if (bus.rsp_valid) begin
                rd  = bus.rsp_rdata;
                er  = bus.rsp_error;
                got = 1'b1;
            end
        end
        if (!got) chk("rsp_timeout", 32'(got), 32'h1);
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [3:0]  exp_mask;
        logic        exp_en;
        logic [5:0]  exp_led;
    } vec_t;

    function automatic vec_t mkv(input string nm, input logic wr, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rd,
                                 input logic er, input logic [3:0] mk, input logic en,
                                 input logic [5:0] ld);
        vec_t v;
        v.name = nm; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rd = rd; v.exp_err = er; v.exp_mask = mk; v.exp_en = en; v.exp_led = ld;
        return v;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t        vecs[$];
        logic [31:0] rd, cadr;
        logic        er, en, stable, seen_rsp;
        logic [3:0]  mk;
        int          lat;

        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = SZ_BYTE;
        bus.req_unsigned = 1'b0;
        bus.req_address  = '0;
        bus.req_wdata    = '0;
        rst_n            = 1'b0;

        //               name        wr  sz  u  addr           wdata          rdata          err  mask     en  led
        vecs.push_back(mkv("sw_10",   1, 2, 0, 32'h0000_0010, 32'h1234_5678, 32'h0,         0, 4'b1111, 1, 6'h00));
        vecs.push_back(mkv("lw_10",   0, 2, 0, 32'h0000_0010, 32'h0,         32'h1234_5678, 0, 4'b0000, 1, 6'h00));
        vecs.push_back(mkv("sb_13",   1, 0, 0, 32'h0000_0013, 32'h0000_00AB, 32'h0,         0, 4'b1000, 1, 6'h00));
        vecs.push_back(mkv("lb_13",   0, 0, 0, 32'h0000_0013, 32'h0,         32'hFFFF_FFAB, 0, 4'b0000, 1, 6'h00));
        vecs.push_back(mkv("lbu_13",  0, 0, 1, 32'h0000_0013, 32'h0,         32'h0000_00AB, 0, 4'b0000, 1, 6'h00));
        vecs.push_back(mkv("lw_10b",  0, 2, 0, 32'h0000_0010, 32'h0,         32'hAB34_5678, 0, 4'b0000, 1, 6'h00));
        vecs.push_back(mkv("sh_16",   1, 1, 0, 32'h0000_0016, 32'h1234_BEEF, 32'h0,         0, 4'b1100, 1, 6'h00));
        vecs.push_back(mkv("lw_14",   0, 2, 0, 32'h0000_0014, 32'h0,         32'hBEEF_0000, 0, 4'b0000, 1, 6'h00));
        vecs.push_back(mkv("lh_16",   0, 1, 0, 32'h0000_0016, 32'h0,         32'hFFFF_BEEF, 0, 4'b0000, 1, 6'h00));
        vecs.push_back(mkv("lhu_16",  0, 1, 1, 32'h0000_0016, 32'h0,         32'h0000_BEEF, 0, 4'b0000, 1, 6'h00));
        vecs.push_back(mkv("lb_11",   0, 0, 0, 32'h0000_0011, 32'h0,         32'h0000_0056, 0, 4'b0000, 1, 6'h00));
        vecs.push_back(mkv("sb_11",   1, 0, 0, 32'h0000_0011, 32'hFFFF_FF9C, 32'h0,         0, 4'b0010, 1, 6'h00));
        vecs.push_back(mkv("lw_10c",  0, 2, 0, 32'h0000_0010, 32'h0,         32'hAB34_9C78, 0, 4'b0000, 1, 6'h00));
        vecs.push_back(mkv("lw_ffc",  0, 2, 0, 32'h0000_0FFC, 32'h0,         32'h0,         0, 4'b0000, 1, 6'h00));
        vecs.push_back(mkv("lh_11",   0, 1, 0, 32'h0000_0011, 32'h0,         32'h0,         1, 4'b0000, 0, 6'h00));
        vecs.push_back(mkv("lw_12",   0, 2, 0, 32'h0000_0012, 32'h0,         32'h0,         1, 4'b0000, 0, 6'h00));
        vecs.push_back(mkv("sz3",     0, 3, 0, 32'h0000_0010, 32'h0,         32'h0,         1, 4'b0000, 0, 6'h00));
        vecs.push_back(mkv("sw_led",  1, 2, 0, 32'hFFFF_FFFC, 32'h0000_003F, 32'h0,         0, 4'b0000, 0, 6'h3F));
        vecs.push_back(mkv("lw_led",  0, 2, 0, 32'hFFFF_FFFC, 32'h0,         32'h0000_003F, 0, 4'b0000, 0, 6'h3F));
        vecs.push_back(mkv("sb_led",  1, 0, 0, 32'hFFFF_FFFD, 32'hFFFF_FFC5, 32'h0,         0, 4'b0000, 0, 6'h05));
        vecs.push_back(mkv("lb_led",  0, 0, 0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0005, 0, 4'b0000, 0, 6'h05));
        vecs.push_back(mkv("lw_top",  0, 2, 0, 32'h0000_1000, 32'h0,         32'h0,         1, 4'b0000, 0, 6'h05));
        vecs.push_back(mkv("sw_fff8", 1, 2, 0, 32'hFFFF_FFF8, 32'h0000_0001, 32'h0,         1, 4'b0000, 0, 6'h05));
        vecs.push_back(mkv("sw_ledm", 1, 2, 0, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0,         1, 4'b0000, 0, 6'h05));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_error", 32'(bus.rsp_error), 32'h0);
        chk("rst_cache_en",  32'(cache_enable), 32'h0);
        chk("rst_cache_adr", cache_address, 32'h0);
        chk("rst_cache_din", cache_data_in, 32'h0);
        chk("rst_cache_we",  32'(cache_write_enable), 32'h0);
        chk("rst_led",       32'(led), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", 32'(bus.req_ready), 32'h1);

        foreach (vecs[i]) begin
            do_req(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   rd, er, mk, en, lat, cadr, stable);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
            chk({vecs[i].name, "_error"}, 32'(er), 32'(vecs[i].exp_err));
            chk({vecs[i].name, "_mask"},  32'(mk), 32'(vecs[i].exp_mask));
            chk({vecs[i].name, "_cen"},   32'(en), 32'(vecs[i].exp_en));
            chk({vecs[i].name, "_led"},   32'(led), 32'(vecs[i].exp_led));
            if (vecs[i].exp_en) begin
                chk({vecs[i].name, "_caddr"},  cadr, {vecs[i].addr[31:2], 2'b00});
                chk({vecs[i].name, "_stable"}, 32'(stable), 32'h1);
            end else begin
                chk({vecs[i].name, "_lat"}, 32'(lat), 32'd1);
            end
            @(negedge clk);
            chk({vecs[i].name, "_pulse"}, 32'(bus.rsp_valid), 32'h0);
        end

        // Cache hit latency: line of 0x10 is resident.
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, rd, er, mk, en, lat, cadr, stable);
        chk("hit_lat",   32'(lat), 32'd3);
        chk("hit_rdata", rd, 32'hAB34_9C78);

        // Dirty-line conflict: 0x810 maps onto the same line as 0x10.
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, rd, er, mk, en, lat, cadr, stable);
        chk("dirty_sw_mask", 32'(mk), 32'hF);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0810, 32'h0, rd, er, mk, en, lat, cadr, stable);
        chk("conflict_rdata",  rd, 32'h5A5A_1234);
        chk("conflict_error",  32'(er), 32'h0);
        chk("conflict_caddr",  cadr, 32'h0000_0810);
        chk("conflict_stable", 32'(stable), 32'h1);
        chk("conflict_waited", 32'(lat > 3), 32'h1);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, rd, er, mk, en, lat, cadr, stable);
        chk("reload_10", rd, 32'hCAFE_F00D);

        // Reset asserted while the DUT waits on a cache miss.
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b0;
        bus.req_size     = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_address  = 32'h0000_0410;
        chk("midrst_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_in_wait", 32'(cache_enable && cache_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_cen",   32'(cache_enable), 32'h0);
        chk("midrst_caddr", cache_address, 32'h0);
        chk("midrst_rsp",   32'(bus.rsp_valid), 32'h0);
        chk("midrst_led",   32'(led), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_rsp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen_rsp = seen_rsp | bus.rsp_valid;
        end
        chk("midrst_no_rsp", 32'(seen_rsp), 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h0BAD_F00D, rd, er, mk, en, lat, cadr, stable);
        chk("post_sw_err", 32'(er), 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, rd, er, mk, en, lat, cadr, stable);
        chk("post_lw_20", rd, 32'h0BAD_F00D);
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_0812, 32'h0, rd, er, mk, en, lat, cadr, stable);
        chk("post_lbu_812", rd, 32'h0000_005A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
